// File: rtl/hmap_pkg.sv
// Shared types for the hmap_pipe arithmetic pipeline.
package hmap_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    PASS = 2'b00,
    WRAP = 2'b01,
    SAT  = 2'b10,
    ACC  = 2'b11
  } hmap_mode_e;

endpackage

// File: rtl/hmap_delay.sv
// Valid-tagged shift register of N stages with clock enable and async active-low reset.
module hmap_delay
  import hmap_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  input  logic         d_vld,
  output logic [W-1:0] q,
  output logic         q_vld
);

  logic [W-1:0] data  [N];
  logic [N-1:0] valid;

  // Each enabled edge moves every stage forward by one; a stall freezes the whole line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        data[i] <= '0;
      end
      valid <= '0;
    end else if (en) begin
      data[0]  <= d;
      valid[0] <= d_vld;
      for (int i = 1; i < int'(N); i++) begin
        data[i]  <= data[i-1];
        valid[i] <= valid[i-1];
      end
    end
  end

  assign q     = data[N-1];
  assign q_vld = valid[N-1];

endmodule

// File: rtl/hmap_pipe.sv
// Mode-selectable stage-0 arithmetic with sticky overflow, followed by a valid-tagged delay line.
module hmap_pipe
  import hmap_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_vld,
  input  logic [MODE_W-1:0] opt,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic              clr_ovf,
  output logic [W-1:0]      x,
  output logic              x_vld,
  output logic [W-1:0]      y,
  output logic              y_vld,
  output logic              ovf
);

  hmap_mode_e mode;
  logic       accept;
  logic [W:0] sum_ab;
  logic [W:0] sum_acc;
  logic [W-1:0] s0_next;
  logic       carry;

  assign mode   = hmap_mode_e'(opt);
  assign accept = en && in_vld;

  // Stage-0 next value and carry; ACC folds in whatever x currently holds.
  always_comb begin
    s0_next = x;
    carry   = 1'b0;
    sum_ab  = {1'b0, a} + {1'b0, b};
    sum_acc = {1'b0, x} + {1'b0, a};
    case (mode)
      PASS: s0_next = a;
      WRAP: begin
        s0_next = sum_ab[W-1:0];
        carry   = sum_ab[W];
      end
      SAT: begin
        s0_next = sum_ab[W] ? {W{1'b1}} : sum_ab[W-1:0];
        carry   = sum_ab[W];
      end
      ACC: begin
        s0_next = sum_acc[W-1:0];
        carry   = sum_acc[W];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x     <= '0;
      x_vld <= 1'b0;
    end else if (en) begin
      x_vld <= in_vld;
      if (in_vld) begin
        x <= s0_next;
      end
    end
  end

  // Sticky flag: an overflowing accept beats a simultaneous clear; clear ignores en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (accept && carry) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  generate
    if (DEPTH > 1) begin : g_delay
      hmap_delay #(
        .W(W),
        .N(DEPTH - 1)
      ) u_delay (
        .clk   (clk),
        .rst_n (rst),
        .en    (en),
        .d     (x),
        .d_vld (x_vld),
        .q     (y),
        .q_vld (y_vld)
      );
    end else begin : g_bypass
      assign y     = x;
      assign y_vld = x_vld;
    end
  endgenerate

endmodule

// File: tb/tb_hmap_pipe.sv
// Directed plus random checks of hmap_pipe at DEPTH 2, 4 and 1 against a reference model and scoreboard.
module tb_hmap_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_vld = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [1:0] opt = 2'b00;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;

  logic [7:0] x2, y2, x4, y4, x1, y1;
  logic       xv2, yv2, ov2, xv4, yv4, ov4, xv1, yv1, ov1;

  logic [7:0] xs [3];
  logic [7:0] ys [3];
  logic       xvs[3];
  logic       yvs[3];
  logic       ovs[3];

  always #5 clk = ~clk;

  hmap_pipe #(.W(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_vld(in_vld), .opt(opt), .a(a), .b(b),
    .clr_ovf(clr_ovf), .x(x2), .x_vld(xv2), .y(y2), .y_vld(yv2), .ovf(ov2));
  hmap_pipe #(.W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_vld(in_vld), .opt(opt), .a(a), .b(b),
    .clr_ovf(clr_ovf), .x(x4), .x_vld(xv4), .y(y4), .y_vld(yv4), .ovf(ov4));
  hmap_pipe #(.W(8), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_vld(in_vld), .opt(opt), .a(a), .b(b),
    .clr_ovf(clr_ovf), .x(x1), .x_vld(xv1), .y(y1), .y_vld(yv1), .ovf(ov1));

  assign xs[0] = x2;  assign xs[1] = x4;  assign xs[2] = x1;
  assign ys[0] = y2;  assign ys[1] = y4;  assign ys[2] = y1;
  assign xvs[0] = xv2; assign xvs[1] = xv4; assign xvs[2] = xv1;
  assign yvs[0] = yv2; assign yvs[1] = yv4; assign yvs[2] = yv1;
  assign ovs[0] = ov2; assign ovs[1] = ov4; assign ovs[2] = ov1;

  typedef struct {
    logic [7:0] data;
    int         k;
  } exp_t;

  exp_t       hist[$];
  int         rd[3];
  int         lag[3] = '{1, 3, 0};
  logic [7:0] m_s0 = 8'd0;
  logic       m_xvld = 1'b0;
  logic       m_ovf = 1'b0;
  int         k = 0;
  int         nassert = 0;
  int         nfail = 0;
  logic [7:0] prev_y[3];
  logic       prev_yv[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic e);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("x[d%0d]", i), 32'(xs[i]), 32'(m_s0));
      chk($sformatf("x_vld[d%0d]", i), 32'(xvs[i]), 32'(m_xvld));
      chk($sformatf("ovf[d%0d]", i), 32'(ovs[i]), 32'(m_ovf));
      if (!e) begin
        chk($sformatf("y_frozen[d%0d]", i), 32'(ys[i]), 32'(prev_y[i]));
        chk($sformatf("y_vld_frozen[d%0d]", i), 32'(yvs[i]), 32'(prev_yv[i]));
      end else if (yvs[i]) begin
        if (rd[i] < hist.size()) begin
          chk($sformatf("y[d%0d]", i), 32'(ys[i]), 32'(hist[rd[i]].data));
          chk($sformatf("y_lag[d%0d]", i), 32'(k), 32'(hist[rd[i]].k + lag[i]));
          rd[i]++;
        end else begin
          chk($sformatf("stray_y_vld[d%0d]", i), 32'(yvs[i]), 32'd0);
        end
      end else if (rd[i] < hist.size() && hist[rd[i]].k + lag[i] == k) begin
        chk($sformatf("missing_y_vld[d%0d]", i), 32'(yvs[i]), 32'd1);
        rd[i]++;
      end
    end
  endtask

  task automatic step(input logic e, input logic v, input logic [1:0] o,
                      input logic [7:0] aa, input logic [7:0] bb, input logic c);
    logic [8:0] s;
    logic       cy;
    en = e; in_vld = v; opt = o; a = aa; b = bb; clr_ovf = c;
    for (int i = 0; i < 3; i++) begin
      prev_y[i]  = ys[i];
      prev_yv[i] = yvs[i];
    end
    @(posedge clk);
    cy = 1'b0;
    if (e) begin
      k++;
      if (v) begin
        s = (o == 2'b11) ? ({1'b0, m_s0} + {1'b0, aa}) : ({1'b0, aa} + {1'b0, bb});
        case (o)
          2'b00:   m_s0 = aa;
          2'b10:   m_s0 = s[8] ? 8'hFF : s[7:0];
          default: m_s0 = s[7:0];
        endcase
        cy = (o != 2'b00) && s[8];
        hist.push_back('{m_s0, k});
      end
      m_xvld = v;
    end
    if (cy) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    #1;
    check_all(e);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_x[d%0d]", tag, i), 32'(xs[i]), 32'd0);
      chk($sformatf("%s_x_vld[d%0d]", tag, i), 32'(xvs[i]), 32'd0);
      chk($sformatf("%s_y[d%0d]", tag, i), 32'(ys[i]), 32'd0);
      chk($sformatf("%s_y_vld[d%0d]", tag, i), 32'(yvs[i]), 32'd0);
      chk($sformatf("%s_ovf[d%0d]", tag, i), 32'(ovs[i]), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rd[i] = 0;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1: WRAP overflow, then idle so y catches up and x_vld drops
    step(1, 1, 2'b01, 8'd200, 8'd100, 0);
    step(1, 0, 2'b01, 8'd0, 8'd0, 0);
    step(1, 0, 2'b00, 8'd0, 8'd0, 1);

    // 2: SAT clamp, ovf stays sticky
    step(1, 1, 2'b10, 8'd200, 8'd100, 0);
    step(1, 1, 2'b10, 8'd3, 8'd4, 0);
    step(1, 0, 2'b00, 8'd0, 8'd0, 0);
    step(1, 0, 2'b00, 8'd0, 8'd0, 1);

    // 3: PASS seed then ACC x3 -> 110, 210, 54
    step(1, 1, 2'b00, 8'd10, 8'd0, 0);
    step(1, 1, 2'b11, 8'd100, 8'd77, 0);
    step(1, 1, 2'b11, 8'd100, 8'd77, 0);
    step(1, 1, 2'b11, 8'd100, 8'd77, 0);
    step(1, 0, 2'b00, 8'd0, 8'd0, 1);

    // 4: stream with a two-cycle stall after the second accept
    step(1, 1, 2'b00, 8'd1, 8'd0, 0);
    step(1, 1, 2'b00, 8'd2, 8'd0, 0);
    step(0, 1, 2'b00, 8'd99, 8'd0, 0);
    step(0, 0, 2'b00, 8'd98, 8'd0, 0);
    step(1, 1, 2'b00, 8'd3, 8'd0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 2'b00, 8'd0, 8'd0, 0);

    // 5: set beats clear, then clear alone while disabled
    step(1, 1, 2'b01, 8'd255, 8'd1, 1);
    step(0, 0, 2'b00, 8'd0, 8'd0, 1);
    step(1, 0, 2'b00, 8'd0, 8'd0, 0);

    // 6: asynchronous reset while a valid sits in stage 1
    step(1, 1, 2'b01, 8'd250, 8'd10, 0);
    step(1, 0, 2'b00, 8'd0, 8'd0, 0);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    m_s0 = 8'd0; m_xvld = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < 3; i++) rd[i] = hist.size();
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 2'b00, 8'd0, 8'd0, 0);

    // Mixed random traffic
    for (int i = 0; i < 60; i++) begin
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           logic'($urandom_range(0, 5) == 0));
    end
    for (int i = 0; i < 5; i++) step(1, 0, 2'b00, 8'd0, 8'd0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drained[d%0d]", i), 32'(rd[i]), 32'(hist.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
